soc: RTL and testbench
======================

SOC -- requirements
Module: soc

Interface
REQ-001 The clock and reset choice SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 The module SHALL have no other ports; behaviour is observed through internal hierarchy only.
REQ-005 The memory instance SHALL be named mem and SHALL hold array data of 4096 entries x 128 bits, so benches can preload it by hierarchical path soc.mem.data, with the program starting at entry 2048.

Function
REQ-006 The module SHALL contain an RV32I-subset core and a unified instruction/data memory.
- Byte address A maps to entry A[15:4] and 32-bit word A[3:2] within that entry.
- Entry 2048 equals byte address 0x8000.
REQ-007 The core SHALL be multi-cycle with states FETCH, EXEC, MEM, WB, HALT.
- FETCH -> EXEC always.
- EXEC -> MEM for loads/stores, else -> WB.
- MEM -> WB.
- WB -> FETCH.
- HALT is absorbing until reset.
REQ-008 Memory reads SHALL be synchronous: the address is registered and data is available the next cycle. Writes SHALL be synchronous, 32-bit word only.
REQ-009 Supported instructions SHALL be:
- LUI, AUIPC, JAL, JALR.
- BEQ, BNE, BLT, BGE, BLTU, BGEU.
- LW, SW.
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- ECALL.
REQ-010 Arithmetic SHALL be 32-bit with wrap-around. Shifts SHALL use the low 5 bits of the shift amount. SRA/SRAI SHALL sign-extend.
REQ-011 Register file: 32 x 32 bits, x0 reads 0, writes to x0 ignored.
REQ-012 Branch/jump targets SHALL be PC-relative (JALR: (rs1+imm) with bit 0 cleared). Link value = PC+4, written in WB.
REQ-013 LW/SW SHALL ignore address bits [1:0].
REQ-014 ECALL, EBREAK or any unsupported opcode SHALL enter HALT. In HALT:
- PC is frozen.
- No register or memory writes occur.
REQ-015 An instruction whose rd equals rs1 SHALL read the old value, since the write occurs only in WB.
REQ-016 PC SHALL wrap modulo 2^32. Addresses above 0xFFFF alias into the 64 KiB memory.

Reset
REQ-017 While rst is high:
- PC = 0x0000_8000.
- State = FETCH.
- All registers x1..x31 = 0.
- Halt flag = 0.
REQ-018 Memory contents SHALL NOT be altered by reset.
REQ-019 Reset asserted mid-instruction SHALL abort that instruction with no register or memory write.

Configuration
REQ-020 With macro SOC_MUL_EN defined, the core SHALL implement MUL (funct7=0000001, funct3=000), returning the low 32 bits of the product in the EXEC/WB path. Without it, MUL SHALL be treated as unsupported and enter HALT.

Structure
REQ-021 Package soc_pkg SHALL hold:
- Opcode/funct constants.
- Reset PC 0x8000.
- Memory depth 4096 and line width 128.
- State enum typedef.
REQ-022 Sub-module soc_memory SHALL be instantiated as mem, with a single read/write port and 32-bit word select. The core SHALL be inline in soc.

Verification
REQ-023 Reset, no program -> PC=0x8000, x1..x31=0, state FETCH one cycle after release.
REQ-024 Preload entry 2048 word0 = ADDI x1,x0,5; word1 = ADDI x2,x1,-7; word2 = ECALL -> x1=5, x2=0xFFFFFFFE, core in HALT with PC=0x8008.
REQ-025 Vector sum: 8 words of values 1..8 at 0x9000, loop of LW/ADD/ADDI/BNE, SW of the result to 0x9100, ECALL -> mem word at 0x9100 = 36 within 5000 cycles.
REQ-026 Branches and jumps:
- BLT with x1=-1, x2=1 -> taken.
- BLTU with the same values -> not taken.
- JAL x5 at 0x8010 -> x5=0x8014.
REQ-027 ADDI x0,x0,9 -> x0 still 0. Assert rst during MEM of an SW -> target word unchanged, PC=0x8000.
REQ-028 MUL x3,x1,x2 with x1=7, x2=-3 -> x3=0xFFFFFFEB with SOC_MUL_EN defined; HALT without it.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared constants, state encoding and ALU helper for the soc RV32I-subset core.
package soc_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_8000;
    localparam int unsigned MEM_DEPTH = 4096;
    localparam int unsigned LINE_W    = 128;
    localparam int unsigned AW        = 12;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // alt selects SUB for F3_ADD and arithmetic shift for F3_SR
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        y = '0;
        case (f3)
            F3_ADD:  y = alt ? (a - b) : (a + b);
            F3_SLL:  y = a << b[4:0];
            F3_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: y = {31'b0, a < b};
            F3_XOR:  y = a ^ b;
            F3_SR:   y = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            F3_OR:   y = a | b;
            F3_AND:  y = a & b;
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/soc_memory.sv
// Unified 4096 x 128-bit memory: registered read address, synchronous 32-bit word writes.
module soc_memory
    import soc_pkg::*;
(
    input  logic          i_clk,
    input  logic [AW-1:0] i_line,
    input  logic [1:0]    i_wsel,
    input  logic          i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [LINE_W-1:0] data [MEM_DEPTH];
    logic [AW-1:0]     r_line;
    logic [1:0]        r_wsel;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            data[i_line][{i_wsel, 5'b0} +: 32] <= i_wdata;
        end
        r_line <= i_line;
        r_wsel <= i_wsel;
    end

    assign o_rdata = data[r_line][{r_wsel, 5'b0} +: 32];

endmodule

// File: rtl/soc.sv
// Multi-cycle RV32I-subset core with unified memory instance mem.
// Define SOC_MUL_EN to add MUL; otherwise MUL halts like any unsupported opcode.
module soc
    import soc_pkg::*;
(
    input logic clk,
    input logic rst
);

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_alu, r_npc, r_maddr, r_sdata;
    logic [4:0]  r_rd;
    logic        r_rd_we, r_is_load, r_is_store, r_halt;
    logic [31:0] r_regs [32];

    logic [31:0] w_rdata, w_addr;
    logic        w_mem_we;
    logic        w_unused;

    // The instruction is consumed straight from the read port during EXEC
    logic [31:0] w_ir;
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_rs1v, w_rs2v;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_res, w_npc, w_maddr;
    logic        w_we, w_load, w_store, w_ill, w_take;

    assign w_ir    = w_rdata;
    assign w_op    = w_ir[6:0];
    assign w_rd    = w_ir[11:7];
    assign w_f3    = w_ir[14:12];
    assign w_rs1   = w_ir[19:15];
    assign w_rs2   = w_ir[24:20];
    assign w_f7    = w_ir[31:25];
    assign w_rs1v  = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2v  = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign w_imm_i = {{20{w_ir[31]}}, w_ir[31:20]};
    assign w_imm_s = {{20{w_ir[31]}}, w_ir[31:25], w_ir[11:7]};
    assign w_imm_b = {{19{w_ir[31]}}, w_ir[31], w_ir[7], w_ir[30:25], w_ir[11:8], 1'b0};
    assign w_imm_u = {w_ir[31:12], 12'b0};
    assign w_imm_j = {{11{w_ir[31]}}, w_ir[31], w_ir[19:12], w_ir[20], w_ir[30:21], 1'b0};

    always_comb begin
        w_res   = '0;
        w_npc   = r_pc + 32'd4;
        w_maddr = w_rs1v + w_imm_i;
        w_we    = 1'b0;
        w_load  = 1'b0;
        w_store = 1'b0;
        w_ill   = 1'b0;
        w_take  = 1'b0;
        case (w_op)
            OP_LUI: begin
                w_res = w_imm_u;
                w_we  = 1'b1;
            end
            OP_AUIPC: begin
                w_res = r_pc + w_imm_u;
                w_we  = 1'b1;
            end
            OP_JAL: begin
                w_res = r_pc + 32'd4;
                w_npc = r_pc + w_imm_j;
                w_we  = 1'b1;
            end
            OP_JALR: begin
                if (w_f3 == 3'b000) begin
                    w_res = r_pc + 32'd4;
                    w_npc = (w_rs1v + w_imm_i) & ~32'd1;
                    w_we  = 1'b1;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OP_BRANCH: begin
                case (w_f3)
                    F3_BEQ:  w_take = (w_rs1v == w_rs2v);
                    F3_BNE:  w_take = (w_rs1v != w_rs2v);
                    F3_BLT:  w_take = ($signed(w_rs1v) < $signed(w_rs2v));
                    F3_BGE:  w_take = ($signed(w_rs1v) >= $signed(w_rs2v));
                    F3_BLTU: w_take = (w_rs1v < w_rs2v);
                    F3_BGEU: w_take = (w_rs1v >= w_rs2v);
                    default: w_ill  = 1'b1;
                endcase
                if (w_take) begin
                    w_npc = r_pc + w_imm_b;
                end
            end
            OP_LOAD: begin
                w_load = (w_f3 == F3_LW);
                w_we   = (w_f3 == F3_LW);
                w_ill  = (w_f3 != F3_LW);
            end
            OP_STORE: begin
                w_maddr = w_rs1v + w_imm_s;
                w_store = (w_f3 == F3_LW);
                w_ill   = (w_f3 != F3_LW);
            end
            OP_IMM: begin
                if ((w_f3 == F3_SLL && w_f7 != F7_BASE) ||
                    (w_f3 == F3_SR && w_f7 != F7_BASE && w_f7 != F7_ALT)) begin
                    w_ill = 1'b1;
                end else begin
                    w_res = alu(w_f3, (w_f3 == F3_SR) && w_ir[30], w_rs1v, w_imm_i);
                    w_we  = 1'b1;
                end
            end
            OP_REG: begin
                if (w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == F3_ADD || w_f3 == F3_SR))) begin
                    w_res = alu(w_f3, w_ir[30], w_rs1v, w_rs2v);
                    w_we  = 1'b1;
                end
`ifdef SOC_MUL_EN
                else if (w_f7 == F7_MULDIV && w_f3 == F3_ADD) begin
                    w_res = w_rs1v * w_rs2v;
                    w_we  = 1'b1;
                end
`endif
                else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: w_next = S_EXEC;
            S_EXEC:  w_next = w_ill ? S_HALT : ((w_load || w_store) ? S_MEM : S_WB);
            S_MEM:   w_next = S_WB;
            S_WB:    w_next = S_FETCH;
            default: w_next = S_HALT;
        endcase
    end

    always_comb begin
        case (r_state)
            S_EXEC:  w_addr = w_maddr;
            S_MEM:   w_addr = r_maddr;
            default: w_addr = r_pc;
        endcase
    end

    assign w_mem_we = (r_state == S_MEM) && r_is_store;
    assign w_unused = ^{w_addr[31:16], w_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_alu      <= '0;
            r_npc      <= '0;
            r_maddr    <= '0;
            r_sdata    <= '0;
            r_rd       <= '0;
            r_rd_we    <= 1'b0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_halt     <= 1'b0;
            r_regs     <= '{default: '0};
        end else begin
            r_state <= w_next;
            case (r_state)
                S_EXEC: begin
                    if (w_ill) begin
                        r_halt <= 1'b1;
                    end else begin
                        r_alu      <= w_res;
                        r_npc      <= w_npc;
                        r_rd       <= w_rd;
                        r_rd_we    <= w_we;
                        r_is_load  <= w_load;
                        r_is_store <= w_store;
                        r_maddr    <= w_maddr;
                        r_sdata    <= w_rs2v;
                    end
                end
                S_MEM: begin
                    if (r_is_load) begin
                        r_alu <= w_rdata;
                    end
                end
                S_WB: begin
                    r_pc <= r_npc;
                    if (r_rd_we && r_rd != 5'd0) begin
                        r_regs[r_rd] <= r_alu;
                    end
                end
                default: ;
            endcase
        end
    end

    soc_memory mem (
        .i_clk   (clk),
        .i_line  (w_addr[15:4]),
        .i_wsel  (w_addr[3:2]),
        .i_we    (w_mem_we),
        .i_wdata (r_sdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_soc.sv
// Self-checking bench for soc: instruction vector table plus hand-written multi-cycle sequences.
module tb_soc;
    import soc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    soc dut (
        .clk (clk),
        .rst (rst)
    );

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
    } exp_t;

    vec_t vt[20];
    int   nv;
    exp_t sb[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, F3_LW, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] j_t(input logic [20:1] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    // Memory preload goes through NBAs and settles before the core leaves reset
    task automatic put_word(input logic [31:0] addr, input logic [31:0] val);
        logic [127:0] t;
        t = dut.mem.data[addr[15:4]];
        t[{addr[3:2], 5'b0} +: 32] = val;
        dut.mem.data[addr[15:4]] <= t;
        #1;
    endtask

    function automatic logic [31:0] get_word(input logic [31:0] addr);
        logic [127:0] t;
        t = dut.mem.data[addr[15:4]];
        return t[{addr[3:2], 5'b0} +: 32];
    endfunction

    task automatic begin_test();
        rst = 1'b1;
        @(negedge clk);
        for (int l = 0; l < 32; l++) begin
            dut.mem.data[12'(2048 + l)] <= '0;
            dut.mem.data[12'(16'h900 + l)] <= '0;
        end
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        bit halted;
        halted = 1'b0;
        for (int c = 0; c < budget && !halted; c++) begin
            @(negedge clk);
            halted = (dut.r_state == S_HALT);
        end
        check32({name, "_halt"}, {31'b0, halted}, 32'd1);
    endtask

    initial begin
        logic [31:0] acc;
        logic [4:0]  idx;
        bit          seen;
        exp_t        e;

        nv = 0;
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3),  32'd5, 32'd7, 5'd3, 32'd12, 32'h8010};
        vt[nv++] = '{r_t(F7_ALT, 5'd2, 5'd1, F3_ADD, 5'd3),   32'd5, 32'd7, 5'd3, 32'hFFFF_FFFE, 32'h8010};
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_SLT, 5'd3),  32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1, 32'h8010};
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_SLTU, 5'd3), 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd0, 32'h8010};
        vt[nv++] = '{r_t(F7_ALT, 5'd2, 5'd1, F3_SR, 5'd3),    32'h8000_0000, 32'd33, 5'd3, 32'hC000_0000, 32'h8010};
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_SR, 5'd3),   32'h8000_0000, 32'd33, 5'd3, 32'h4000_0000, 32'h8010};
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_SLL, 5'd3),  32'd1, 32'd31, 5'd3, 32'h8000_0000, 32'h8010};
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_XOR, 5'd3),  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3, 32'h0FF0_0FF0, 32'h8010};
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd3),   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3, 32'hFFF0_FFF0, 32'h8010};
        vt[nv++] = '{r_t(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd3),  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3, 32'hF000_F000, 32'h8010};
        vt[nv++] = '{i_t(12'h404, 5'd1, F3_SR, 5'd3, OP_IMM),   32'h8000_0000, 32'd0, 5'd3, 32'hF800_0000, 32'h8010};
        vt[nv++] = '{i_t(12'hFFF, 5'd1, F3_SLTU, 5'd3, OP_IMM), 32'd5, 32'd0, 5'd3, 32'd1, 32'h8010};
        vt[nv++] = '{i_t(12'h001, 5'd1, F3_ADD, 5'd3, OP_IMM),  32'hFFFF_FFFF, 32'd0, 5'd3, 32'd0, 32'h8010};
        vt[nv++] = '{i_t(12'h009, 5'd0, F3_ADD, 5'd0, OP_IMM),  32'd0, 32'd0, 5'd0, 32'd0, 32'h8010};
        vt[nv++] = '{b_t(12'h004, 5'd2, 5'd1, F3_BLT),  32'hFFFF_FFFF, 32'd1, 5'd3, 32'd0, 32'h8014};
        vt[nv++] = '{b_t(12'h004, 5'd2, 5'd1, F3_BLTU), 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd0, 32'h8010};
        vt[nv++] = '{b_t(12'h004, 5'd2, 5'd1, F3_BGEU), 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd0, 32'h8014};
        vt[nv++] = '{b_t(12'h004, 5'd2, 5'd1, F3_BEQ),  32'd9, 32'd9, 5'd3, 32'd0, 32'h8014};
        vt[nv++] = '{32'hFFFF_FFFF, 32'd1, 32'd2, 5'd3, 32'd0, 32'h800C};
`ifdef SOC_MUL_EN
        vt[nv++] = '{r_t(F7_MULDIV, 5'd2, 5'd1, F3_ADD, 5'd3), 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 32'h8010};
`else
        vt[nv++] = '{r_t(F7_MULDIV, 5'd2, 5'd1, F3_ADD, 5'd3), 32'd7, 32'hFFFF_FFFD, 5'd3, 32'd0, 32'h800C};
`endif

        // Template: x4=0x9000, x1/x2 loaded from 0x9000/0x9004, op under test at 0x800C
        for (int v = 0; v < nv; v++) begin
            begin_test();
            put_word(32'h8000, u_t(20'h9, 5'd4, OP_LUI));
            put_word(32'h8004, i_t(12'h000, 5'd4, F3_LW, 5'd1, OP_LOAD));
            put_word(32'h8008, i_t(12'h004, 5'd4, F3_LW, 5'd2, OP_LOAD));
            put_word(32'h800C, vt[v].instr);
            put_word(32'h8010, ECALL);
            put_word(32'h8014, ECALL);
            put_word(32'h9000, vt[v].a);
            put_word(32'h9004, vt[v].b);
            sb.push_back('{vt[v].rd, vt[v].exp, vt[v].pc});
            release_rst();
            run_to_halt($sformatf("vec%0d", v), 200);
            e = sb.pop_front();
            check32($sformatf("vec%0d_rd", v), dut.r_regs[e.rd], e.val);
            check32($sformatf("vec%0d_pc", v), dut.r_pc, e.pc);
        end

        // Two ADDIs then ECALL: x2 depends on x1 written back by the previous instruction
        begin_test();
        put_word(32'h8000, i_t(12'h005, 5'd0, F3_ADD, 5'd1, OP_IMM));
        put_word(32'h8004, i_t(12'hFF9, 5'd1, F3_ADD, 5'd2, OP_IMM));
        put_word(32'h8008, ECALL);
        release_rst();
        run_to_halt("addi", 100);
        check32("addi_x1", dut.r_regs[1], 32'd5);
        check32("addi_x2", dut.r_regs[2], 32'hFFFF_FFFE);
        check32("addi_pc", dut.r_pc, 32'h8008);
        check32("addi_halt_flag", {31'b0, dut.r_halt}, 32'd1);

        // Reset after a run clears registers and halt, and restarts at 0x8000
        @(negedge clk);
        rst = 1'b1;
        #1;
        acc = '0;
        for (int i = 1; i < 32; i++) begin
            idx = 5'(i);
            acc = acc | dut.r_regs[idx];
        end
        check32("rst_regs_zero", acc, 32'd0);
        check32("rst_pc", dut.r_pc, RESET_PC);
        check32("rst_state", 32'(dut.r_state), 32'(S_FETCH));
        check32("rst_halt_flag", {31'b0, dut.r_halt}, 32'd0);
        begin_test();
        release_rst();
        #1;
        check32("rel_state", 32'(dut.r_state), 32'(S_FETCH));
        check32("rel_pc", dut.r_pc, RESET_PC);
        run_to_halt("empty", 20);
        check32("empty_pc", dut.r_pc, RESET_PC);

        // JAL x5 located at 0x8010 jumps over an ECALL
        begin_test();
        put_word(32'h8000, NOP);
        put_word(32'h8004, NOP);
        put_word(32'h8008, NOP);
        put_word(32'h800C, NOP);
        put_word(32'h8010, j_t(20'h00004, 5'd5));
        put_word(32'h8014, ECALL);
        put_word(32'h8018, ECALL);
        release_rst();
        run_to_halt("jal", 100);
        check32("jal_x5", dut.r_regs[5], 32'h8014);
        check32("jal_pc", dut.r_pc, 32'h8018);

        // Vector sum of 1..8 stored to 0x9100
        begin_test();
        put_word(32'h8000, u_t(20'h9, 5'd4, OP_LUI));
        put_word(32'h8004, i_t(12'h008, 5'd0, F3_ADD, 5'd5, OP_IMM));
        put_word(32'h8008, i_t(12'h000, 5'd0, F3_ADD, 5'd6, OP_IMM));
        put_word(32'h800C, i_t(12'h000, 5'd4, F3_LW, 5'd7, OP_LOAD));
        put_word(32'h8010, r_t(F7_BASE, 5'd7, 5'd6, F3_ADD, 5'd6));
        put_word(32'h8014, i_t(12'h004, 5'd4, F3_ADD, 5'd4, OP_IMM));
        put_word(32'h8018, i_t(12'hFFF, 5'd5, F3_ADD, 5'd5, OP_IMM));
        put_word(32'h801C, b_t(12'hFF8, 5'd0, 5'd5, F3_BNE));
        put_word(32'h8020, u_t(20'h9, 5'd8, OP_LUI));
        put_word(32'h8024, s_t(12'h100, 5'd6, 5'd8));
        put_word(32'h8028, ECALL);
        for (int k = 0; k < 8; k++) begin
            put_word(32'h9000 + 32'(4 * k), 32'(k + 1));
        end
        release_rst();
        run_to_halt("vsum", 5000);
        check32("vsum_mem", get_word(32'h9100), 32'd36);
        check32("vsum_pc", dut.r_pc, 32'h8028);

        // Reset in the MEM cycle of a SW aborts the store
        begin_test();
        put_word(32'h8000, u_t(20'h9, 5'd4, OP_LUI));
        put_word(32'h8004, i_t(12'h055, 5'd0, F3_ADD, 5'd6, OP_IMM));
        put_word(32'h8008, s_t(12'h200, 5'd6, 5'd4));
        put_word(32'h800C, ECALL);
        put_word(32'h9200, 32'hDEAD_BEEF);
        release_rst();
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = (dut.r_state == S_MEM);
        end
        check32("swrst_mem_seen", {31'b0, seen}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check32("swrst_pc", dut.r_pc, RESET_PC);
        check32("swrst_state", 32'(dut.r_state), 32'(S_FETCH));
        @(posedge clk);
        #1;
        check32("swrst_word", get_word(32'h9200), 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
